crc_engine_ctrl: RTL and testbench

//  Parametrised CRC generate/check engine with its own packet sequencer.

---
 rtl/crc_engine_ctrl_if.sv | 30 +++
 rtl/crc_engine_ctrl.sv | 89 ++++++++
 tb/tb_crc_engine_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/crc_engine_ctrl_if.sv
// crc_engine_ctrl_if: packet control, payload input and CRC output signals of the CRC engine
interface crc_engine_ctrl_if #(
  parameter int CRC_W = 24,
  parameter int DIN_W = 1,
  parameter int LEN_W = 12
);
  logic             start;
  logic             mode;
  logic [CRC_W-1:0] init;
  logic [LEN_W-1:0] len;
  logic             abort;
  logic [DIN_W-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic [DIN_W-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             done;
  logic             crc_ok;
  logic             busy;
  logic [CRC_W-1:0] lfsr;
  modport master (
    output start, mode, init, len, abort, din, din_valid, dout_ready,
    input  din_ready, dout, dout_valid, done, crc_ok, busy, lfsr
  );
  modport slave (
    input  start, mode, init, len, abort, din, din_valid, dout_ready,
    output din_ready, dout, dout_valid, done, crc_ok, busy, lfsr
  );
endinterface

// File: rtl/crc_engine_ctrl.sv
// crc_engine_ctrl: CRC generate/check engine with packet sequencer (TX streams CRC, RX flags crc_ok)
// Ports: clk, rst (async, active-high); bus (slave): start/mode/init/len/abort packet control,
//   din/din_valid/din_ready payload in, dout/dout_valid/dout_ready CRC out (TX),
//   done pulse, crc_ok result (RX), busy, lfsr state.
module crc_engine_ctrl #(
  parameter int               CRC_W          = 24,
  parameter logic [CRC_W-1:0] POLY           = CRC_W'(24'h65B),
  parameter int               DIN_W          = 1,
  parameter int               LEN_W          = 12,
  parameter bit               BYTE_SWAP_INIT = 1'b1
) (
  input logic             clk,
  input logic             rst,
  crc_engine_ctrl_if.slave bus
);
  localparam int NB    = CRC_W / DIN_W;
  localparam int CNT_W = LEN_W > $clog2(NB + 1) ? LEN_W : $clog2(NB + 1);
  typedef enum logic [1:0] {IDLE, DATA, CRC, DONE} state_t;
  state_t st, st_n;
  logic             mode_q, crc_ok_q, rdy, vld, fire, last;
  logic [LEN_W-1:0] len_q;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic [CRC_W-1:0] lfsr_q, lfsr_n, sh;
  logic [DIN_W-1:0] dout;
  function automatic logic [CRC_W-1:0] step(input logic [CRC_W-1:0] s, input logic [DIN_W-1:0] d);
    logic [CRC_W-1:0] r;
    r = s;
    for (int i = 0; i < DIN_W; i++) r = {r[CRC_W-2:0], 1'b0} ^ ((r[CRC_W-1] ^ d[i]) ? POLY : '0);
    return r;
  endfunction
  function automatic logic [CRC_W-1:0] load(input logic [CRC_W-1:0] v);
    logic [CRC_W-1:0] r;
    r = v;
    if (BYTE_SWAP_INIT && CRC_W % 8 == 0)
      for (int i = 0; i < CRC_W / 8; i++) r[i*8 +: 8] = v[(CRC_W/8-1-i)*8 +: 8];
    return r;
  endfunction
  always_comb begin
    rdy     = st == DATA || (st == CRC && mode_q);
    vld     = st == CRC && !mode_q;
    fire    = (rdy && bus.din_valid) || (vld && bus.dout_ready);
    cnt_inc = cnt + CNT_W'(1);
    last    = st == DATA ? cnt_inc == CNT_W'(len_q) : cnt_inc == CNT_W'(NB);
    lfsr_n  = step(lfsr_q, bus.din);
    st_n    = bus.abort ? IDLE :
              st == IDLE ? (bus.start ? (bus.len == '0 ? CRC : DATA) : IDLE) :
              st == DONE ? IDLE :
              fire && last ? (st == DATA ? CRC : DONE) : st;
  end
  // the remaining CRC is shifted so that the next beat's bits sit at the top
  always_comb begin
    sh   = lfsr_q << (int'(cnt) * DIN_W);
    dout = '0;
    for (int j = 0; j < DIN_W; j++) dout[j] = vld & sh[CRC_W-1-j];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= IDLE;
      mode_q   <= 1'b0;
      len_q    <= '0;
      cnt      <= '0;
      lfsr_q   <= '0;
      crc_ok_q <= 1'b0;
    end else begin
      st <= st_n;
      if (bus.abort) begin
        cnt <= '0;
      end else if (st == IDLE && bus.start) begin
        mode_q   <= bus.mode;
        len_q    <= bus.len;
        cnt      <= '0;
        lfsr_q   <= load(bus.init);
        crc_ok_q <= 1'b0;
      end else if (fire) begin
        cnt <= last ? '0 : cnt_inc;
        if (rdy) lfsr_q <= lfsr_n;
        // result is registered on the final CRC beat so it is already valid while done is high
        if (st == CRC && last) crc_ok_q <= mode_q && lfsr_n == '0;
      end
    end
  end
  assign bus.din_ready  = rdy;
  assign bus.dout_valid = vld;
  assign bus.dout       = dout;
  assign bus.done       = st == DONE;
  assign bus.crc_ok     = crc_ok_q;
  assign bus.busy       = st != IDLE;
  assign bus.lfsr       = lfsr_q;
endmodule

// File: tb/tb_crc_engine_ctrl.sv
// tb_crc_engine_ctrl: randomized self-checking bench for crc_engine_ctrl against a bit-serial CRC model
module tb_crc_engine_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int d1 = 0;
  always #5 clk = ~clk;
  crc_engine_ctrl_if #(.CRC_W(24), .DIN_W(1), .LEN_W(12)) b1();
  crc_engine_ctrl_if #(.CRC_W(24), .DIN_W(8), .LEN_W(12)) b8();
  crc_engine_ctrl #(.CRC_W(24), .POLY(24'h65B), .DIN_W(1), .LEN_W(12), .BYTE_SWAP_INIT(1'b0))
    u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  crc_engine_ctrl #(.CRC_W(24), .POLY(24'h65B), .DIN_W(8), .LEN_W(12), .BYTE_SWAP_INIT(1'b1))
    u8 (.clk(clk), .rst(rst), .bus(b8.slave));
  always @(posedge clk) if (b1.done) d1++;
  function automatic logic [23:0] mstep(input logic [23:0] s, input logic b);
    return {s[22:0], 1'b0} ^ ((s[23] ^ b) ? 24'h00065B : 24'h0);
  endfunction
  function automatic logic [23:0] bswap(input logic [23:0] x);
    return {x[7:0], x[15:8], x[23:16]};
  endfunction
  task automatic go1(input logic m, input logic [23:0] ini, input logic [11:0] n);
    b1.start = 1'b1; b1.mode = m; b1.init = ini; b1.len = n;
    @(negedge clk);
    b1.start = 1'b0; b1.mode = ~m; b1.init = $urandom; b1.len = $urandom;
  endtask
  task automatic go8(input logic m, input logic [23:0] ini, input logic [11:0] n);
    b8.start = 1'b1; b8.mode = m; b8.init = ini; b8.len = n;
    @(negedge clk);
    b8.start = 1'b0; b8.mode = ~m; b8.init = $urandom; b8.len = $urandom;
  endtask
  task automatic feed1(input logic b);
    bit acc;
    int t;
    acc = 0; t = 0; b1.din = b;
    while (!acc && t < 40) begin
      b1.din_valid = $urandom_range(0, 3) != 0;
      acc = b1.din_valid && b1.din_ready;
      @(negedge clk);
      t++;
    end
    b1.din_valid = 1'b0; b1.din = $urandom;
    checks++;
    if (!acc) begin errors++; $display("FAIL feed1 timeout: din_ready=%b required 1", b1.din_ready); end
  endtask
  task automatic feed8(input logic [7:0] b);
    bit acc;
    int t;
    acc = 0; t = 0; b8.din = b;
    while (!acc && t < 40) begin
      b8.din_valid = $urandom_range(0, 3) != 0;
      acc = b8.din_valid && b8.din_ready;
      @(negedge clk);
      t++;
    end
    b8.din_valid = 1'b0; b8.din = $urandom;
    checks++;
    if (!acc) begin errors++; $display("FAIL feed8 timeout: din_ready=%b required 1", b8.din_ready); end
  endtask
  task automatic take1(output logic b, input bit rnd);
    bit got;
    int t;
    got = 0; t = 0; b = 1'b0;
    while (!got && t < 40) begin
      b1.dout_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      got = b1.dout_valid && b1.dout_ready;
      if (got) b = b1.dout;
      @(negedge clk);
      t++;
    end
    b1.dout_ready = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL take1 timeout: dout_valid=%b required 1", b1.dout_valid); end
  endtask
  task automatic take8(output logic [7:0] b);
    bit got;
    int t;
    got = 0; t = 0; b = '0;
    while (!got && t < 40) begin
      b8.dout_ready = $urandom_range(0, 3) != 0;
      got = b8.dout_valid && b8.dout_ready;
      if (got) b = b8.dout;
      @(negedge clk);
      t++;
    end
    b8.dout_ready = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL take8 timeout: dout_valid=%b required 1", b8.dout_valid); end
  endtask
  task automatic wait_done1(output logic ok);
    int t;
    t = 0;
    while (!b1.done && t < 8) begin @(negedge clk); t++; end
    checks++;
    if (!b1.done) begin errors++; $display("FAIL done1 timeout: done=%b required 1", b1.done); end
    ok = b1.crc_ok;
    @(negedge clk);
  endtask
  task automatic wait_done8(output logic ok);
    int t;
    t = 0;
    while (!b8.done && t < 8) begin @(negedge clk); t++; end
    checks++;
    if (!b8.done) begin errors++; $display("FAIL done8 timeout: done=%b required 1", b8.done); end
    ok = b8.crc_ok;
    @(negedge clk);
  endtask
  task automatic test_reset;
    logic [55:0] o1, o8;
    b1.start = 0; b1.mode = 0; b1.init = 0; b1.len = 0; b1.abort = 0; b1.din = 0; b1.din_valid = 0; b1.dout_ready = 0;
    b8.start = 0; b8.mode = 0; b8.init = 0; b8.len = 0; b8.abort = 0; b8.din = 0; b8.din_valid = 0; b8.dout_ready = 0;
    repeat (2) @(negedge clk);
    o1 = {b1.lfsr, b1.din_ready, b1.dout_valid, b1.done, b1.crc_ok, b1.busy, 27'(b1.dout)};
    o8 = {b8.lfsr, b8.din_ready, b8.dout_valid, b8.done, b8.crc_ok, b8.busy, 27'(b8.dout)};
    checks++;
    if (o1 !== '0) begin errors++; $display("FAIL reset1: outputs=%h required 0", o1); end
    checks++;
    if (o8 !== '0) begin errors++; $display("FAIL reset8: outputs=%h required 0", o8); end
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_tx;
    logic [23:0] got;
    logic b, ok;
    go1(1'b0, 24'h800000, 12'd1);
    checks++;
    if (b1.lfsr !== 24'h800000 || b1.din_ready !== 1'b1) begin
      errors++; $display("FAIL tx_load: lfsr=%h rdy=%b required 800000 1", b1.lfsr, b1.din_ready);
    end
    feed1(1'b0);
    checks++;
    if (b1.lfsr !== 24'h00065B) begin errors++; $display("FAIL tx_beat: lfsr=%h required 00065b", b1.lfsr); end
    got = '0;
    for (int k = 0; k < 24; k++) begin take1(b, 1'b1); got[23-k] = b; end
    checks++;
    if (got !== 24'h00065B) begin errors++; $display("FAIL tx_stream: got=%h required 00065b", got); end
    wait_done1(ok);
    checks++;
    if (ok !== 1'b0 || b1.busy !== 1'b0) begin errors++; $display("FAIL tx_done: crc_ok=%b busy=%b required 0 0", ok, b1.busy); end
  endtask
  task automatic test_rx;
    logic [23:0] c, e;
    logic ok;
    c = 24'h00065B;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) c[$urandom_range(0, 23)] ^= 1'b1;
      go1(1'b1, 24'h800000, 12'd1);
      checks++;
      if (b1.crc_ok !== 1'b0) begin errors++; $display("FAIL rx_clear: crc_ok=%b required 0", b1.crc_ok); end
      feed1(1'b0);
      e = 24'h00065B;
      for (int k = 0; k < 24; k++) begin feed1(c[23-k]); e = mstep(e, c[23-k]); end
      wait_done1(ok);
      checks++;
      if (ok !== (pass == 0) || b1.lfsr !== e) begin
        errors++; $display("FAIL rx_result%0d: crc_ok=%b lfsr=%h required %b %h", pass, ok, b1.lfsr, pass == 0, e);
      end
      checks++;
      if (b1.crc_ok !== (pass == 0)) begin errors++; $display("FAIL rx_hold%0d: crc_ok=%b required %b", pass, b1.crc_ok, pass == 0); end
    end
  endtask
  task automatic test_len0_stall;
    logic [23:0] c, got;
    logic b, ok, stable;
    c = 24'hABCDEF; got = '0; stable = 1'b1;
    go1(1'b0, c, 12'd0);
    checks++;
    if (b1.din_ready !== 1'b0 || b1.dout_valid !== 1'b1) begin
      errors++; $display("FAIL len0_state: din_ready=%b dout_valid=%b required 0 1", b1.din_ready, b1.dout_valid);
    end
    for (int k = 0; k < 10; k++) begin take1(b, 1'b0); got[23-k] = b; end
    for (int k = 0; k < 5; k++) begin
      if (b1.dout !== c[13] || b1.dout_valid !== 1'b1) stable = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (stable !== 1'b1) begin errors++; $display("FAIL stall_dout: dout=%b required %b while stalled", b1.dout, c[13]); end
    for (int k = 10; k < 24; k++) begin take1(b, 1'b0); got[23-k] = b; end
    checks++;
    if (got !== c) begin errors++; $display("FAIL len0_stream: got=%h required %h", got, c); end
    wait_done1(ok);
  endtask
  task automatic test_abort;
    logic [23:0] s, ini, got;
    logic b, ok;
    int dc;
    ini = $urandom; s = ini;
    go1(1'b0, ini, 12'd10);
    for (int k = 0; k < 3; k++) begin b = $urandom; feed1(b); s = mstep(s, b); end
    dc = d1;
    b1.abort = 1'b1;
    @(negedge clk);
    b1.abort = 1'b0;
    checks++;
    if (b1.busy !== 1'b0 || b1.lfsr !== s) begin
      errors++; $display("FAIL abort_data: busy=%b lfsr=%h required 0 %h", b1.busy, b1.lfsr, s);
    end
    b1.abort = 1'b1; b1.start = 1'b1;
    @(negedge clk);
    b1.abort = 1'b0; b1.start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (b1.busy !== 1'b0 || d1 !== dc) begin
      errors++; $display("FAIL abort_prio: busy=%b dones=%0d required 0 %0d", b1.busy, d1, dc);
    end
    ini = $urandom; s = ini;
    go1(1'b0, ini, 12'd2);
    for (int k = 0; k < 2; k++) begin
      b = $urandom; feed1(b); s = mstep(s, b);
      if (k == 0) begin
        b1.start = 1'b1; b1.init = ~ini;
        @(negedge clk);
        b1.start = 1'b0;
      end
    end
    got = '0;
    for (int k = 0; k < 24; k++) begin take1(b, 1'b1); got[23-k] = b; end
    wait_done1(ok);
    checks++;
    if (got !== s || d1 !== dc + 1) begin
      errors++; $display("FAIL after_abort: crc=%h dones=%0d required %h %0d", got, d1 - dc, s, 1);
    end
    go1(1'b0, $urandom, 12'd0);
    for (int k = 0; k < 5; k++) take1(b, 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({b1.lfsr, b1.din_ready, b1.dout_valid, b1.done, b1.crc_ok, b1.busy, b1.dout} !== '0) begin
      errors++; $display("FAIL rst_mid_crc: lfsr=%h busy=%b dout_valid=%b required all 0", b1.lfsr, b1.busy, b1.dout_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_swap_load;
    logic [23:0] s, got;
    logic [7:0] bt;
    logic ok;
    go8(1'b0, 24'h000001, 12'd1);
    checks++;
    if (b8.lfsr !== 24'h010000) begin errors++; $display("FAIL swap_load: lfsr=%h required 010000", b8.lfsr); end
    feed8(8'h00);
    s = 24'h010000;
    for (int j = 0; j < 8; j++) s = mstep(s, 1'b0);
    got = '0;
    for (int k = 0; k < 3; k++) begin take8(bt); for (int j = 0; j < 8; j++) got[23-8*k-j] = bt[j]; end
    wait_done8(ok);
    checks++;
    if (got !== s) begin errors++; $display("FAIL swap_stream: got=%h required %h", got, s); end
  endtask
  task automatic test_random8;
    for (int it = 0; it < 6; it++) begin
      logic [23:0] ini, s, got, c, e, flip;
      logic [7:0] pl[20];
      logic [7:0] bt;
      logic ok;
      ini = $urandom; s = bswap(ini);
      for (int i = 0; i < 20; i++) begin
        pl[i] = $urandom;
        for (int j = 0; j < 8; j++) s = mstep(s, pl[i][j]);
      end
      go8(1'b0, ini, 12'd20);
      checks++;
      if (b8.lfsr !== bswap(ini)) begin errors++; $display("FAIL r8_load%0d: lfsr=%h required %h", it, b8.lfsr, bswap(ini)); end
      for (int i = 0; i < 20; i++) feed8(pl[i]);
      got = '0;
      for (int k = 0; k < 3; k++) begin take8(bt); for (int j = 0; j < 8; j++) got[23-8*k-j] = bt[j]; end
      wait_done8(ok);
      checks++;
      if (got !== s || ok !== 1'b0) begin errors++; $display("FAIL r8_tx%0d: crc=%h ok=%b required %h 0", it, got, ok, s); end
      flip = it[0] ? (24'h1 << $urandom_range(0, 23)) : 24'h0;
      c = got ^ flip;
      go8(1'b1, ini, 12'd20);
      for (int i = 0; i < 20; i++) feed8(pl[i]);
      e = s;
      for (int k = 0; k < 3; k++) begin
        for (int j = 0; j < 8; j++) begin bt[j] = c[23-8*k-j]; e = mstep(e, bt[j]); end
        feed8(bt);
      end
      wait_done8(ok);
      checks++;
      if (b8.lfsr !== e || ok !== (flip == 0)) begin
        errors++; $display("FAIL r8_rx%0d: lfsr=%h ok=%b required %h %b", it, b8.lfsr, ok, e, flip == 0);
      end
    end
  endtask
  initial begin
    test_reset();
    test_tx();
    test_rx();
    test_len0_stall();
    test_abort();
    test_swap_load();
    test_random8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end
endmodule
